mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max wait cycles for mem_ready per access; 0 disables timeout.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  in  7  IR[6:0] of the current instruction.
REQ-005 SHALL have port branch_taken  in  1  datapath comparator result for the current branch.
REQ-006 SHALL have port mem_ready  in  1  memory completes the current request this cycle.
REQ-007 SHALL have ports pc_ce, ir_ce, ab_ce, aluout_ce, mdr_ce  out  1 each  CE of the corresponding 32-bit datapath registers; ir_ce also drives the OLDPC register.
REQ-008 SHALL have ports rf_we, mem_req, mem_we, iord  out  1 each  regfile write, memory request, memory write, address select (0=PC, 1=ALUOUT).
REQ-009 SHALL have ports alu_src_a, alu_src_b, alu_op, pc_src, wb_sel  out  2 each  mux selects, encodings per REQ-013.
REQ-010 SHALL have ports error  out  1  sticky fault flag; err_cause  out  2  01=illegal opcode, 10=memory timeout.

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, ERR; control outputs decoded from state, opcode, mem_ready, branch_taken.
REQ-012 Supported opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-013 Encodings: alu_src_a 00 OLDPC/01 A/10 ZERO; alu_src_b 00 B/01 IMM/10 FOUR; alu_op 00 ADD/01 FUNCT/10 CMP; pc_src 00 PC+4/01 ALUOUT/10 ALU; wb_sel 00 ALUOUT/01 MDR/10 LINK(PC reg); unlisted selects SHALL be 00.
REQ-014 FETCH: mem_req=1, iord=0; when mem_ready=1: ir_ce=1, pc_ce=1 (pc_src=00), next DECODE; else stay.
REQ-015 DECODE: ab_ce=1, aluout_ce=1 with OLDPC+IMM (ADD); next EXEC, or ERR with err_cause=01 if opcode unsupported.
REQ-016 EXEC R: A,B,FUNCT, aluout_ce -> WB; I-ALU: A,IMM,FUNCT -> WB; LUI: ZERO,IMM,ADD -> WB; AUIPC: OLDPC,IMM,ADD -> WB (all with aluout_ce=1).
REQ-017 EXEC LOAD/STORE: A,IMM,ADD, aluout_ce=1 -> MEM.
REQ-018 EXEC BRANCH: A,B,CMP; pc_src=01, pc_ce=branch_taken -> FETCH.
REQ-019 EXEC JAL: rf_we=1, wb_sel=10, pc_src=01, pc_ce=1 -> FETCH; JALR: same but A,IMM,ADD and pc_src=10; link written from pre-edge PC value in same cycle.
REQ-020 MEM: mem_req=1, iord=1, mem_we=1 for STORE; on mem_ready: LOAD mdr_ce=1 -> WB, STORE -> FETCH.
REQ-021 WB: rf_we=1, wb_sel=01 for LOAD else 00 -> FETCH.
REQ-022 Wait counter SHALL increment each cycle mem_req=1 and mem_ready=0, clear on any state change; reaching MEM_TIMEOUT (nonzero) -> ERR, err_cause=10.
REQ-023 mem_ready on the cycle the counter hits MEM_TIMEOUT SHALL win (access completes, no error).
REQ-024 ERR: all CE/we/req outputs 0, error=1; held until rst.
REQ-025 mem_ready outside FETCH/MEM SHALL be ignored; mem_req SHALL remain high until mem_ready (no request withdrawal).

Reset
REQ-026 rst=1 SHALL immediately force state FETCH, counter 0, error=0, err_cause=00, and all CE/we/req outputs and selects 0 while rst is held.
REQ-027 Reset mid-access SHALL abandon the access; first cycle after release issues a fresh FETCH.

Structure
REQ-028 Package mc_ctrl_pkg SHALL hold state encoding, opcode constants, all REQ-013 select encodings, err_cause codes.
REQ-029 Sub-module mc_opdec SHALL map opcode to instruction class plus valid flag (combinational); mc_ctrl holds FSM and counter.

Verification
REQ-030 R-type, mem_ready always 1 -> 4 cycles FETCH-DECODE-EXEC-WB, rf_we=1 only in WB with wb_sel=00.
REQ-031 LOAD, mem_ready 3 cycles late in MEM -> mem_req held 4 cycles, mdr_ce pulses once, 5+3 cycles total.
REQ-032 BRANCH with branch_taken=0 then 1 -> 3 cycles each, pc_ce in EXEC 0 then 1, pc_src=01.
REQ-033 opcode 7'b1111111 -> ERR after DECODE, error=1, err_cause=01, no CE until rst.
REQ-034 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERR after 4 wait cycles, err_cause=10; mem_ready on 4th cycle -> DECODE, no error.
REQ-035 rst pulsed during MEM of STORE -> mem_we drops asynchronously, FETCH restarts, no rf_we.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, instruction classes, datapath mux selects and fault codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_OLDPC = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_ZERO  = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_CMP    = 2'b10;

    localparam logic [1:0] PCS_PC4    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_ALU    = 2'b10;

    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_LINK    = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_opdec.sv
// Opcode classifier: maps IR[6:0] to an instruction class and a supported flag.
module mc_opdec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        iclass = CL_R;
        valid  = 1'b1;
        unique case (opcode)
            OP_R:      iclass = CL_R;
            OP_I:      iclass = CL_I;
            OP_LOAD:   iclass = CL_LOAD;
            OP_STORE:  iclass = CL_STORE;
            OP_BRANCH: iclass = CL_BRANCH;
            OP_JAL:    iclass = CL_JAL;
            OP_JALR:   iclass = CL_JALR;
            OP_LUI:    iclass = CL_LUI;
            OP_AUIPC:  iclass = CL_AUIPC;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM with bounded memory wait and a sticky fault state.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       pc_ce,
    output logic       ir_ce,
    output logic       ab_ce,
    output logic       aluout_ce,
    output logic       mdr_ce,
    output logic       rf_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] wb_sel,
    output logic       error,
    output logic [1:0] err_cause
);

    // The FSM leaves a wait state once the counter reaches MEM_TIMEOUT-1 with no ready,
    // so the counter never needs to represent MEM_TIMEOUT itself.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, cnt_next;
    logic [1:0]       cause_next;
    iclass_t          iclass;
    logic             valid;
    logic             timeout_hit;

    mc_opdec u_opdec (
        .opcode (opcode),
        .iclass (iclass),
        .valid  (valid)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Outputs stay at zero while rst is asserted so an in-flight access is dropped at once.
    always_comb begin
        state_next = state;
        cause_next = ERR_NONE;
        pc_ce      = 1'b0;
        ir_ce      = 1'b0;
        ab_ce      = 1'b0;
        aluout_ce  = 1'b0;
        mdr_ce     = 1'b0;
        rf_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PCS_PC4;
        wb_sel     = WB_ALUOUT;
        error      = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_ce      = 1'b1;
                        pc_ce      = 1'b1;
                        state_next = ST_DECODE;
                    end else if (timeout_hit) begin
                        state_next = ST_ERR;
                        cause_next = ERR_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    ab_ce     = 1'b1;
                    aluout_ce = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (valid) begin
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_ERR;
                        cause_next = ERR_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    state_next = ST_FETCH;
                    unique case (iclass)
                        CL_R:      begin alu_src_a = SRCA_A;    alu_op = ALU_FUNCT; aluout_ce = 1'b1; state_next = ST_WB; end
                        CL_I:      begin alu_src_a = SRCA_A;    alu_src_b = SRCB_IMM; alu_op = ALU_FUNCT; aluout_ce = 1'b1; state_next = ST_WB; end
                        CL_LUI:    begin alu_src_a = SRCA_ZERO; alu_src_b = SRCB_IMM; aluout_ce = 1'b1; state_next = ST_WB; end
                        CL_AUIPC:  begin alu_src_b = SRCB_IMM;  aluout_ce = 1'b1; state_next = ST_WB; end
                        CL_LOAD,
                        CL_STORE:  begin alu_src_a = SRCA_A;    alu_src_b = SRCB_IMM; aluout_ce = 1'b1; state_next = ST_MEM; end
                        CL_BRANCH: begin alu_src_a = SRCA_A;    alu_op = ALU_CMP; pc_src = PCS_ALUOUT; pc_ce = branch_taken; end
                        CL_JAL:    begin rf_we = 1'b1; wb_sel = WB_LINK; pc_src = PCS_ALUOUT; pc_ce = 1'b1; end
                        CL_JALR:   begin
                            alu_src_a = SRCA_A;
                            alu_src_b = SRCB_IMM;
                            rf_we     = 1'b1;
                            wb_sel    = WB_LINK;
                            pc_src    = PCS_ALU;
                            pc_ce     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (iclass == CL_STORE);
                    if (mem_ready) begin
                        if (iclass == CL_STORE) begin
                            state_next = ST_FETCH;
                        end else begin
                            mdr_ce     = 1'b1;
                            state_next = ST_WB;
                        end
                    end else if (timeout_hit) begin
                        state_next = ST_ERR;
                        cause_next = ERR_TIMEOUT;
                    end
                end
                ST_WB: begin
                    rf_we      = 1'b1;
                    wb_sel     = (iclass == CL_LOAD) ? WB_MDR : WB_ALUOUT;
                    state_next = ST_FETCH;
                end
                ST_ERR:  error = 1'b1;
                default: state_next = ST_ERR;
            endcase
        end

        cnt_next = wait_cnt;
        if (state_next != state)
            cnt_next = '0;
        else if (mem_req && !mem_ready)
            cnt_next = wait_cnt + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FETCH;
            wait_cnt  <= '0;
            err_cause <= ERR_NONE;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
            if (cause_next != ERR_NONE)
                err_cause <= cause_next;
        end
    end

endmodule
